// File: rtl/multi_cycle_controller.sv
// Multi-cycle control unit for a MIPS-style datapath.
// Decodes IR fields per state into datapath strobes and counts retired instructions.
module multi_cycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        ALUZeroFlag,
  input  logic        memReady,
  output logic [2:0]  operation,
  output logic        ALUSrc,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic [1:0]  pcSrc,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    BRANCH,
    JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;

  state_t state;
  state_t nextState;

  logic isRType;
  logic isImm;
  logic isSlti;
  logic isMem;
  logic isLw;
  logic isBr;
  logic isBeq;
  logic isBne;
  logic isJ;

  logic [2:0] rOp;
  logic       rLegal;
  logic [2:0] iOp;
  logic       taken;
  logic       setIllegal;
  logic       retire;

  assign isRType = (opcode == OP_RTYPE);
  assign isSlti  = (opcode == OP_SLTI);
  assign isImm   = (opcode == OP_ADDI) || isSlti;
  assign isLw    = (opcode == OP_LW);
  assign isMem   = isLw || (opcode == OP_SW);
  assign isBeq   = (opcode == OP_BEQ);
  assign isBne   = (opcode == OP_BNE);
  assign isBr    = isBeq || isBne;
  assign isJ     = (opcode == OP_J);

  assign iOp   = isSlti ? ALU_SLT : ALU_ADD;
  assign taken = (isBeq && ALUZeroFlag) ||
                 (isBne && !ALUZeroFlag);

  always_comb begin
    rOp    = ALU_ADD;
    rLegal = 1'b1;
    unique case (funct)
      FN_ADD:  rOp = ALU_ADD;
      FN_SUB:  rOp = ALU_SUB;
      FN_AND:  rOp = ALU_AND;
      FN_OR:   rOp = ALU_OR;
      FN_SLT:  rOp = ALU_SLT;
      default: rLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      illegal <= 1'b0;
      retired <= 16'h0000;
    end else begin
      state   <= nextState;
      illegal <= illegal | setIllegal;
      retired <= retired + {15'b0, retire};
    end
  end

  always_comb begin
    nextState  = state;
    setIllegal = 1'b0;
    retire     = 1'b0;
    operation  = ALU_ADD;
    ALUSrc     = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    pcSrc      = PC_SEQ;
    unique case (state)
      FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          isRType: nextState = EXEC_R;
          isImm:   nextState = EXEC_I;
          isMem:   nextState = ADDR;
          isBr:    nextState = BRANCH;
          isJ:     nextState = JUMP;
          default: begin
            nextState  = FETCH;
            setIllegal = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        operation = rOp;
        nextState = WB_R;
      end
      WB_R: begin
        operation  = rOp;
        regDst     = 1'b1;
        regWrite   = rLegal;
        setIllegal = !rLegal;
        retire     = rLegal;
        nextState  = FETCH;
      end
      EXEC_I: begin
        ALUSrc    = 1'b1;
        operation = iOp;
        nextState = WB_I;
      end
      WB_I: begin
        ALUSrc    = 1'b1;
        operation = iOp;
        regWrite  = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      ADDR: begin
        ALUSrc    = 1'b1;
        nextState = isLw ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        ALUSrc  = 1'b1;
        memRead = 1'b1;
        if (memReady) nextState = MEM_WB;
      end
      MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      MEM_WRITE: begin
        ALUSrc   = 1'b1;
        memWrite = 1'b1;
        if (memReady) begin
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
      BRANCH: begin
        operation = ALU_SUB;
        // Not-taken branches still retire; they just leave PC alone.
        if (taken) begin
          pcWrite = 1'b1;
          pcSrc   = PC_BR;
        end
        retire    = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        pcWrite   = 1'b1;
        pcSrc     = PC_J;
        retire    = 1'b1;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller.
// Inputs change after the falling edge; outputs are sampled 1ns later.
module tb_multi_cycle_controller;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        ALUZeroFlag;
  logic        memReady;
  logic [2:0]  operation;
  logic        ALUSrc;
  logic        irWrite;
  logic        pcWrite;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic        regDst;
  logic        memToReg;
  logic [1:0]  pcSrc;
  logic        illegal;
  logic [15:0] retired;

  int checks;
  int failures;

  multi_cycle_controller dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .funct(funct),
    .ALUZeroFlag(ALUZeroFlag),
    .memReady(memReady),
    .operation(operation),
    .ALUSrc(ALUSrc),
    .irWrite(irWrite),
    .pcWrite(pcWrite),
    .memRead(memRead),
    .memWrite(memWrite),
    .regWrite(regWrite),
    .regDst(regDst),
    .memToReg(memToReg),
    .pcSrc(pcSrc),
    .illegal(illegal),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [12:0] IR   = 13'h1000;
  localparam logic [12:0] PC   = 13'h0800;
  localparam logic [12:0] MR   = 13'h0400;
  localparam logic [12:0] MW   = 13'h0200;
  localparam logic [12:0] RW   = 13'h0100;
  localparam logic [12:0] RD   = 13'h0080;
  localparam logic [12:0] MTR  = 13'h0040;
  localparam logic [12:0] AS   = 13'h0020;
  localparam logic [12:0] SRC2 = 13'h0010;
  localparam logic [12:0] SRC1 = 13'h0008;
  localparam logic [12:0] OAND = 13'h0000;
  localparam logic [12:0] OOR  = 13'h0001;
  localparam logic [12:0] OADD = 13'h0002;
  localparam logic [12:0] OSUB = 13'h0006;
  localparam logic [12:0] OSLT = 13'h0007;

  localparam logic [12:0] FETCH_RDY = IR | PC | MR | OADD;

  logic [12:0] outs;
  assign outs = {irWrite, pcWrite, memRead, memWrite, regWrite,
                 regDst, memToReg, ALUSrc, pcSrc, operation};

  task automatic chkO(input string tag, input logic [12:0] exp);
    checks++;
    assert (outs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  task automatic chkR(input string tag, input logic [15:0] exp);
    checks++;
    assert (retired === exp) else begin
      failures++;
      $error("FAIL %s retired observed=%h expected=%h", tag, retired, exp);
    end
  endtask

  task automatic chkI(input string tag, input logic exp);
    checks++;
    assert (illegal === exp) else begin
      failures++;
      $error("FAIL %s illegal observed=%b expected=%b", tag, illegal, exp);
    end
  endtask

  task automatic step(input string tag, input logic [12:0] exp);
    #1;
    chkO(tag, exp);
    @(negedge clk);
  endtask

  task automatic doReset();
    memReady = 1'b0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  fns [4];
    logic [12:0] ops [4];
    fns = '{6'h22, 6'h24, 6'h25, 6'h2A};
    ops = '{OSUB, OAND, OOR, OSLT};
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    opcode      = 6'h00;
    funct       = 6'h00;
    ALUZeroFlag = 1'b0;
    memReady    = 1'b0;

    #2;
    chkO("rst_outs", MR | OADD);
    chkR("rst_ret", 16'h0000);
    chkI("rst_ill", 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    step("post_rst_hold", MR | OADD);

    // add
    opcode   = 6'h00;
    funct    = 6'h20;
    memReady = 1'b1;
    step("add_fetch", FETCH_RDY);
    step("add_dec", OADD);
    step("add_exec", OADD);
    step("add_wb", RW | RD | OADD);
    #1 chkR("add_ret", 16'd1);

    for (int i = 0; i < 4; i++) begin
      funct = fns[i];
      step("r_fetch", FETCH_RDY);
      step("r_dec", OADD);
      step("r_exec", ops[i]);
      step("r_wb", RW | RD | ops[i]);
    end
    #1 chkR("r_ret", 16'd5);

    opcode = 6'h08;
    step("addi_fetch", FETCH_RDY);
    step("addi_dec", OADD);
    step("addi_exec", AS | OADD);
    step("addi_wb", RW | AS | OADD);
    opcode = 6'h0A;
    step("slti_fetch", FETCH_RDY);
    step("slti_dec", OADD);
    step("slti_exec", AS | OSLT);
    step("slti_wb", RW | AS | OSLT);
    #1 chkR("imm_ret", 16'd7);

    // lw with two wait cycles: 7 cycles total
    opcode = 6'h23;
    step("lw_fetch", FETCH_RDY);
    step("lw_dec", OADD);
    step("lw_addr", AS | OADD);
    memReady = 1'b0;
    step("lw_wait1", MR | AS | OADD);
    step("lw_wait2", MR | AS | OADD);
    memReady = 1'b1;
    step("lw_rdy", MR | AS | OADD);
    step("lw_wb", RW | MTR | OADD);
    #1 chkR("lw_ret", 16'd8);

    opcode = 6'h2B;
    step("sw_fetch", FETCH_RDY);
    step("sw_dec", OADD);
    step("sw_addr", AS | OADD);
    step("sw_mem", MW | AS | OADD);
    #1 chkR("sw_ret", 16'd9);

    opcode      = 6'h04;
    ALUZeroFlag = 1'b1;
    step("beq_fetch", FETCH_RDY);
    step("beq_dec", OADD);
    step("beq_taken", PC | SRC1 | OSUB);
    opcode = 6'h05;
    step("bne_fetch", FETCH_RDY);
    step("bne_dec", OADD);
    step("bne_nt", OSUB);
    ALUZeroFlag = 1'b0;
    step("bne2_fetch", FETCH_RDY);
    step("bne2_dec", OADD);
    step("bne_taken", PC | SRC1 | OSUB);
    opcode = 6'h04;
    step("beq2_fetch", FETCH_RDY);
    step("beq2_dec", OADD);
    step("beq_nt", OSUB);
    #1 chkR("br_ret", 16'd13);

    opcode = 6'h02;
    step("j_fetch", FETCH_RDY);
    step("j_dec", OADD);
    step("j_jump", PC | SRC2 | OADD);
    #1 chkR("j_ret", 16'd14);
    chkI("legal_ill", 1'b0);

    // unsupported opcode, with a fetch stall first
    opcode   = 6'h3F;
    memReady = 1'b0;
    step("ill_stall", MR | OADD);
    memReady = 1'b1;
    step("ill_fetch", FETCH_RDY);
    step("ill_dec", OADD);
    #1 chkI("ill_set", 1'b1);
    chkR("ill_ret", 16'd14);
    step("ill_back", FETCH_RDY);
    @(negedge clk);
    opcode = 6'h02;
    step("j2_fetch", FETCH_RDY);
    step("j2_dec", OADD);
    step("j2_jump", PC | SRC2 | OADD);
    #1 chkI("ill_sticky", 1'b1);
    chkR("j2_ret", 16'd15);

    doReset();
    #1 chkR("rst2_ret", 16'd0);
    chkI("rst2_ill", 1'b0);

    // unsupported funct
    opcode   = 6'h00;
    funct    = 6'h3F;
    memReady = 1'b1;
    step("bf_fetch", FETCH_RDY);
    step("bf_dec", OADD);
    step("bf_exec", OADD);
    step("bf_wb", RD | OADD);
    #1 chkI("bf_ill", 1'b1);
    chkR("bf_ret", 16'd0);
    opcode = 6'h02;
    step("j3_fetch", FETCH_RDY);
    step("j3_dec", OADD);
    step("j3_jump", PC | SRC2 | OADD);
    #1 chkR("j3_ret", 16'd1);

    // reset in the middle of a sw wait
    opcode = 6'h2B;
    step("sw2_fetch", FETCH_RDY);
    step("sw2_dec", OADD);
    step("sw2_addr", AS | OADD);
    memReady = 1'b0;
    #1 chkO("sw2_wait", MW | AS | OADD);
    #1 rst_n = 1'b0;
    #1 chkO("sw2_rst", MR | OADD);
    chkR("sw2_rst_ret", 16'd0);
    chkI("sw2_rst_ill", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    step("sw2_after", MR | OADD);

    // counter wrap
    force dut.retired = 16'hFFFF;
    #1 release dut.retired;
    #1 chkR("pre_wrap", 16'hFFFF);
    @(negedge clk);
    opcode   = 6'h02;
    memReady = 1'b1;
    step("w_fetch", FETCH_RDY);
    step("w_dec", OADD);
    #1 chkR("w_hold", 16'hFFFF);
    step("w_jump", PC | SRC2 | OADD);
    #1 chkR("wrap", 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
